// File: rtl/id_ex_reg.sv
// id_ex_reg: ID/EX pipeline register for a 5-stage MIPS-style core.
// Latches decoded control, operands and register fields from decode into
// execute, inserts bubbles on flush or load-use hazard, holds on stall.
// Optional feature: define HAZARD_DETECT_EN to enable load-use hazard
// detection (hazard_stall output and automatic bubble insertion). With the
// macro undefined, hazard_stall is tied to 0 and only flush makes bubbles.
module id_ex_reg #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              RegDst,
  input  logic              Branch,
  input  logic              MemRead,
  input  logic              MemtoReg,
  input  logic              MemWrite,
  input  logic              ALUSrc,
  input  logic              RegWrite,
  input  logic [1:0]        ALUOp,
  input  logic [DATA_W-1:0] id_pc4,
  input  logic [DATA_W-1:0] id_rdata1,
  input  logic [DATA_W-1:0] id_rdata2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic [4:0]        id_rd,
  output logic              ex_RegDst,
  output logic              ex_Branch,
  output logic              ex_MemRead,
  output logic              ex_MemtoReg,
  output logic              ex_MemWrite,
  output logic              ex_ALUSrc,
  output logic              ex_RegWrite,
  output logic [1:0]        ex_ALUOp,
  output logic [DATA_W-1:0] ex_pc4,
  output logic [DATA_W-1:0] ex_rdata1,
  output logic [DATA_W-1:0] ex_rdata2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [4:0]        ex_rs,
  output logic [4:0]        ex_rt,
  output logic [4:0]        ex_rd,
  output logic              ex_valid,
  output logic              hazard_stall
);

  // Control bundle layout: {RegDst, Branch, MemRead, MemtoReg, MemWrite,
  // ALUSrc, RegWrite, ALUOp[1:0]}.
  localparam int CTL_W = 9;

  // ---- Stage p0: decode-side inputs ----
  logic [CTL_W-1:0]  ctl_p0;
  logic              bubble_p0;

  // ---- Stage p1: EX-side registered entry ----
  logic [CTL_W-1:0]  ctl_p1;
  logic [DATA_W-1:0] pc4_p1;
  logic [DATA_W-1:0] rdata1_p1;
  logic [DATA_W-1:0] rdata2_p1;
  logic [DATA_W-1:0] imm_p1;
  logic [4:0]        rs_p1;
  logic [4:0]        rt_p1;
  logic [4:0]        rd_p1;
  logic              vld_p1;

  assign ctl_p0 = {RegDst, Branch, MemRead, MemtoReg, MemWrite,
                   ALUSrc, RegWrite, ALUOp};

`ifdef HAZARD_DETECT_EN
  // Load-use hazard: the load now in EX writes a register the decoding
  // instruction reads. $zero never creates a dependency. Because the bubble
  // this triggers clears the MemRead bit, the flag lasts one cycle per load
  // unless stall holds the entry in place.
  always_comb begin
    hazard_stall = vld_p1 & ctl_p1[6] & (rt_p1 != 5'd0) &
                   ((rt_p1 == id_rs) | (rt_p1 == id_rt));
  end
`else
  // Hazard detection disabled: never request an upstream hold.
  always_comb begin
    hazard_stall = 1'b0;
  end
`endif

  assign bubble_p0 = hazard_stall;

  // Entry update: reset, flush-bubble, hold, hazard-bubble, then normal load.
  // Bubbles still capture data fields; only control and valid are cleared.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctl_p1    <= '0;
      vld_p1    <= 1'b0;
      pc4_p1    <= '0;
      rdata1_p1 <= '0;
      rdata2_p1 <= '0;
      imm_p1    <= '0;
      rs_p1     <= '0;
      rt_p1     <= '0;
      rd_p1     <= '0;
    end else if (flush || (!stall && bubble_p0)) begin
      ctl_p1    <= '0;
      vld_p1    <= 1'b0;
      pc4_p1    <= id_pc4;
      rdata1_p1 <= id_rdata1;
      rdata2_p1 <= id_rdata2;
      imm_p1    <= id_imm;
      rs_p1     <= id_rs;
      rt_p1     <= id_rt;
      rd_p1     <= id_rd;
    end else if (!stall) begin
      ctl_p1    <= ctl_p0;
      vld_p1    <= 1'b1;
      pc4_p1    <= id_pc4;
      rdata1_p1 <= id_rdata1;
      rdata2_p1 <= id_rdata2;
      imm_p1    <= id_imm;
      rs_p1     <= id_rs;
      rt_p1     <= id_rt;
      rd_p1     <= id_rd;
    end
  end

  // ---- Stage p1 outputs: straight from registers, no id_* feed-through ----
  assign {ex_RegDst, ex_Branch, ex_MemRead, ex_MemtoReg, ex_MemWrite,
          ex_ALUSrc, ex_RegWrite, ex_ALUOp} = ctl_p1;
  assign ex_pc4    = pc4_p1;
  assign ex_rdata1 = rdata1_p1;
  assign ex_rdata2 = rdata2_p1;
  assign ex_imm    = imm_p1;
  assign ex_rs     = rs_p1;
  assign ex_rt     = rt_p1;
  assign ex_rd     = rd_p1;
  assign ex_valid  = vld_p1;

endmodule

// File: tb/tb_id_ex_reg.sv
// tb_id_ex_reg: directed plus randomized bench for id_ex_reg against a
// behavioural model of the ID/EX entry. Honors HAZARD_DETECT_EN the same way
// the design does.
module tb_id_ex_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, stall, flush;
  logic [8:0]  in_ctl;
  logic [31:0] pc4, rd1, rd2, imm;
  logic [4:0]  rs, rt, rd;

  logic        o_RegDst, o_Branch, o_MemRead, o_MemtoReg, o_MemWrite;
  logic        o_ALUSrc, o_RegWrite;
  logic [1:0]  o_ALUOp;
  logic [31:0] o_pc4, o_rd1, o_rd2, o_imm;
  logic [4:0]  o_rs, o_rt, o_rd;
  logic        o_valid, hazard_stall;
  logic [8:0]  o_ctl;

  assign o_ctl = {o_RegDst, o_Branch, o_MemRead, o_MemtoReg, o_MemWrite,
                  o_ALUSrc, o_RegWrite, o_ALUOp};

  id_ex_reg #(.DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .RegDst(in_ctl[8]), .Branch(in_ctl[7]), .MemRead(in_ctl[6]),
    .MemtoReg(in_ctl[5]), .MemWrite(in_ctl[4]), .ALUSrc(in_ctl[3]),
    .RegWrite(in_ctl[2]), .ALUOp(in_ctl[1:0]),
    .id_pc4(pc4), .id_rdata1(rd1), .id_rdata2(rd2), .id_imm(imm),
    .id_rs(rs), .id_rt(rt), .id_rd(rd),
    .ex_RegDst(o_RegDst), .ex_Branch(o_Branch), .ex_MemRead(o_MemRead),
    .ex_MemtoReg(o_MemtoReg), .ex_MemWrite(o_MemWrite), .ex_ALUSrc(o_ALUSrc),
    .ex_RegWrite(o_RegWrite), .ex_ALUOp(o_ALUOp),
    .ex_pc4(o_pc4), .ex_rdata1(o_rd1), .ex_rdata2(o_rd2), .ex_imm(o_imm),
    .ex_rs(o_rs), .ex_rt(o_rt), .ex_rd(o_rd),
    .ex_valid(o_valid), .hazard_stall(hazard_stall)
  );

`ifdef HAZARD_DETECT_EN
  localparam bit HAZ = 1'b1;
`else
  localparam bit HAZ = 1'b0;
`endif

  // Model of the instruction sitting in EX.
  typedef struct packed {
    logic [8:0]  ctl;
    logic [31:0] pc4, r1, r2, imm;
    logic [4:0]  rs, rt, rd;
    logic        v;
  } ent_t;

  ent_t m;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // A load-use hazard exists when the EX entry is a real load whose
  // nonzero destination is a source of the instruction now decoding.
  function automatic bit model_haz();
    return HAZ && m.v && m.ctl[6] && (m.rt != 0) && (m.rt == rs || m.rt == rt);
  endfunction

  function automatic ent_t arriving(input bit is_bubble);
    ent_t e;
    e = '{ctl: in_ctl, pc4: pc4, r1: rd1, r2: rd2, imm: imm,
          rs: rs, rt: rt, rd: rd, v: 1'b1};
    if (is_bubble) begin
      e.ctl = '0;
      e.v   = 1'b0;
    end
    return e;
  endfunction

  // One clock: check hazard before the edge, advance model, check outputs.
  task automatic cycle(input string tag, input bit check_haz);
    bit h;
    #1;
    h = model_haz();
    if (check_haz) chk({tag, "_haz"}, {63'd0, hazard_stall}, {63'd0, h});
    @(posedge clk);
    if (!rst_n)      m = '0;
    else if (flush)  m = arriving(1'b1);
    else if (stall)  m = m;
    else if (h)      m = arriving(1'b1);
    else             m = arriving(1'b0);
    #1;
    chk({tag, "_ctl"},   {55'd0, o_ctl},   {55'd0, m.ctl});
    chk({tag, "_valid"}, {63'd0, o_valid}, {63'd0, m.v});
    chk({tag, "_data"},  {o_pc4, o_rd1},   {m.pc4, m.r1});
    chk({tag, "_data2"}, {o_rd2, o_imm},   {m.r2, m.imm});
    chk({tag, "_regs"},  {49'd0, o_rs, o_rt, o_rd}, {49'd0, m.rs, m.rt, m.rd});
  endtask

  task automatic rand_inputs(input int regmax);
    in_ctl = 9'($urandom);
    pc4    = $urandom;
    rd1    = $urandom;
    rd2    = $urandom;
    imm    = $urandom;
    rs     = 5'($urandom_range(regmax, 0));
    rt     = 5'($urandom_range(regmax, 0));
    rd     = 5'($urandom_range(regmax, 0));
  endtask

  initial begin
    m      = '0;
    rst_n  = 1'b0;
    stall  = 1'b1;
    flush  = 1'b1;
    in_ctl = '1;
    pc4 = '1; rd1 = '1; rd2 = '1; imm = '1;
    rs = '1; rt = '1; rd = '1;

    // Reset held two cycles with every input high.
    cycle("rst0", 1'b0);
    cycle("rst1", 1'b0);
    chk("rst_valid", {63'd0, o_valid}, 64'd0);
    chk("rst_ctl", {55'd0, o_ctl}, 64'd0);

    // R-type load after release.
    rst_n = 1'b1; stall = 1'b0; flush = 1'b0;
    in_ctl = 9'b1_0_0_0_0_0_1_10;
    pc4 = 32'h0000_0104; rd1 = 32'h0000_0005; rd2 = 32'h0000_0007; imm = 32'h0;
    rs = 5'd1; rt = 5'd2; rd = 5'd3;
    cycle("rtype", 1'b1);
    chk("rtype_regdst", {63'd0, o_RegDst}, 64'd1);
    chk("rtype_aluop", {62'd0, o_ALUOp}, 64'd2);
    chk("rtype_rdata1", {32'd0, o_rd1}, 64'h5);
    chk("rtype_valid", {63'd0, o_valid}, 64'd1);

    // lw $8 followed by a consumer reading $8.
    in_ctl = 9'b0_0_1_1_0_1_1_00; rs = 5'd4; rt = 5'd8; rd = 5'd0;
    cycle("lw", 1'b1);
    in_ctl = 9'b1_0_0_0_0_0_1_10; rs = 5'd8; rt = 5'd9; rd = 5'd10;
    #1;
`ifdef HAZARD_DETECT_EN
    chk("lu_haz_on", {63'd0, hazard_stall}, 64'd1);
    cycle("lu_bubble", 1'b1);
    chk("lu_bubble_ctl", {55'd0, o_ctl}, 64'd0);
    chk("lu_bubble_valid", {63'd0, o_valid}, 64'd0);
    #1;
    chk("lu_haz_off", {63'd0, hazard_stall}, 64'd0);
    cycle("lu_consumer", 1'b1);
    chk("lu_consumer_valid", {63'd0, o_valid}, 64'd1);
`else
    chk("lu_haz_tied", {63'd0, hazard_stall}, 64'd0);
    cycle("lu_consumer", 1'b1);
    chk("lu_consumer_valid", {63'd0, o_valid}, 64'd1);
`endif

    // lw to $zero never creates a hazard.
    in_ctl = 9'b0_0_1_1_0_1_1_00; rs = 5'd4; rt = 5'd0;
    cycle("lw0", 1'b1);
    in_ctl = 9'b1_0_0_0_0_0_1_10; rs = 5'd0; rt = 5'd0;
    #1;
    chk("lw0_haz", {63'd0, hazard_stall}, 64'd0);
    cycle("lw0_use", 1'b1);

    // Three stalled cycles with changing inputs, then flush during stall.
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_inputs(31);
      cycle("stall", 1'b1);
    end
    flush = 1'b1;
    rand_inputs(31);
    cycle("flush_stall", 1'b1);
    chk("flush_stall_valid", {63'd0, o_valid}, 64'd0);
    flush = 1'b0; stall = 1'b0;

    // Reset arriving mid-stall discards the held entry.
    rand_inputs(31);
    cycle("pre", 1'b1);
    stall = 1'b1;
    cycle("hold", 1'b1);
    rst_n = 1'b0;
    cycle("rst_stall", 1'b1);
    rst_n = 1'b1; stall = 1'b0;
    in_ctl = 9'b0_0_0_0_0_1_1_00; rs = 5'd1; rt = 5'd2;
    cycle("post_rst", 1'b1);
    chk("post_rst_valid", {63'd0, o_valid}, 64'd1);

    // Random traffic with few registers so hazards occur often.
    for (int i = 0; i < 500; i++) begin
      rand_inputs(3);
      in_ctl[6] = ($urandom_range(1, 0) == 1);
      stall = ($urandom_range(99, 0) < 25);
      flush = ($urandom_range(99, 0) < 10);
      rst_n = ($urandom_range(99, 0) >= 3);
      cycle("rand", 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_reg.md
ID_EX_REG -- requirements
Module: id_ex_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 32, datapath width of register operands, immediate and PC.
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, synchronous active-low reset, sampled on rising clk.
REQ-004 SHALL have port stall, input, 1, downstream hold request; all stage contents held.
REQ-005 SHALL have port flush, input, 1, branch-taken kill; the next captured entry is a bubble.
REQ-006 SHALL have decoded control inputs RegDst, Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite, each input, 1, plus ALUOp, input, 2, from the decode-stage control unit.
REQ-007 SHALL have ports id_pc4, id_rdata1, id_rdata2 and id_imm, each input, DATA_W: PC+4, register-file reads and sign-extended immediate.
REQ-008 SHALL have ports id_rs, id_rt and id_rd, each input, 5: register fields of the decoding instruction.
REQ-009 SHALL have ports ex_RegDst, ex_Branch, ex_MemRead, ex_MemtoReg, ex_MemWrite, ex_ALUSrc and ex_RegWrite, each output, 1, plus ex_ALUOp, output, 2: latched control signals.
REQ-010 SHALL have ports ex_pc4, ex_rdata1, ex_rdata2 and ex_imm, each output, DATA_W, plus ex_rs, ex_rt and ex_rd, each output, 5: latched data and register fields.
REQ-011 SHALL have port ex_valid, output, 1: the EX entry holds a real instruction.
REQ-012 SHALL have port hazard_stall, output, 1: load-use hazard; upstream PC and IF/ID hold.

Function
REQ-013 SHALL apply per-edge priority: reset, then flush, then stall, then hazard bubble, then normal load.
REQ-014 SHALL, on normal load, capture every id_* and control input into the matching ex_* output and set ex_valid=1, giving 1-cycle latency.
REQ-015 SHALL, on bubble (flush, or hazard_stall with stall=0), clear all ex_* control outputs and ALUOp to 0 and set ex_valid=0; data fields SHALL still capture their inputs.
REQ-016 SHALL, on stall=1 with flush=0, hold every output unchanged, including ex_valid.
REQ-017 SHALL drive hazard_stall combinationally as ex_valid & ex_MemRead & (ex_rt!=0) & (ex_rt==id_rs | ex_rt==id_rt).
REQ-018 SHALL keep hazard_stall at most one cycle per load: the bubble clears ex_MemRead, so hazard_stall deasserts on the next cycle.
REQ-019 SHALL, when flush and stall are both 1, insert a bubble (flush wins).
REQ-020 SHALL hold the hazard bubble while stall=1 and insert it when stall first returns to 0 if the hazard persists.
REQ-021 SHALL use no combinational path from any id_* input to any ex_* output.

Reset
REQ-022 SHALL, with rst_n=0 at a rising edge, clear every output register to 0 (ex_valid=0, all controls 0, data and fields 0), regardless of stall or flush.
REQ-023 SHALL force hazard_stall to 0 in the cycle after reset, because ex_valid=0.
REQ-024 SHALL, on reset mid-stall, discard the held entry; the first edge after release loads normally.

Configuration
REQ-025 SHALL, when macro HAZARD_DETECT_EN is defined, implement REQ-017, REQ-018 and REQ-020.
REQ-026 SHALL, when HAZARD_DETECT_EN is undefined, tie hazard_stall to 0 and produce bubbles only from flush; all other behaviour is unchanged.

Verification
REQ-027 SHALL cover: reset held 2 cycles with all inputs 1 -> all outputs 0, ex_valid=0.
REQ-028 SHALL cover: load an R-type (RegDst=1, RegWrite=1, ALUOp=10, id_rdata1=0x00000005) -> next cycle ex_RegDst=1, ex_ALUOp=10, ex_rdata1=0x00000005, ex_valid=1.
REQ-029 SHALL cover: load lw (MemRead=1, id_rt=8) then decode with id_rs=8 -> hazard_stall=1 for exactly 1 cycle, then a bubble with all ex_ controls 0 and ex_valid=0.
REQ-030 SHALL cover: lw with id_rt=0 then a consumer with id_rs=0 -> hazard_stall stays 0.
REQ-031 SHALL cover: stall=1 for 3 cycles while inputs change -> outputs frozen; flush=1 together with stall=1 -> bubble on that edge.
REQ-032 SHALL cover: build with HAZARD_DETECT_EN undefined and repeat the REQ-029 stimulus -> hazard_stall=0 and the consumer loads with ex_valid=1.
